memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- Memory stage of the 5-stage pipeline; sits directly upstream of the memory-to-writeback latch and produces its m_mem_data input.
- Takes the address (ALU result) and store data from the execute-to-memory latch and runs loads/stores against an external data-memory port with a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Handles byte/half/word sizing, sign extension, misalignment and ack timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles waiting for dmem_ack before aborting with a bus error; range 1..255.

Ports:
- clock  in  1  pipeline clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m_mem_read  in  1  current instruction is a load.
- m_mem_write  in  1  current instruction is a store; never set together with m_mem_read.
- m_mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- m_mem_signed  in  1  load result is sign-extended (1) or zero-extended (0).
- m_alu_result  in  32  byte address.
- m_store_data  in  32  store data, right-aligned.
- m_mem_data  out  32  formatted load data to the writeback latch.
- m_stall  out  1  freeze upstream stages and the writeback latch input.
- m_mem_exc  out  1  one-cycle pulse: misaligned access or timeout.
- m_mem_exc_code  out  2  00 none, 01 misaligned, 10 timeout.
- dmem_req  out  1  request valid; held until ack.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word-aligned address; bits [1:0] are 0.
- dmem_wdata  out  32  lane-replicated write data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  single-cycle completion strobe.
- dmem_rdata  in  32  read word; valid when dmem_ack=1.

Behaviour:
- Reset values (reset low, applied asynchronously): state IDLE, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, dmem_be 0, m_mem_data 0, m_mem_exc 0, m_mem_exc_code 00, timeout counter 0.
- m_stall is combinational.
- States:
  - IDLE: access = m_mem_read|m_mem_write.
    - If access and aligned: m_stall=1; register dmem_req=1, dmem_we, dmem_addr={addr[31:2],2'b00}, dmem_be, dmem_wdata; go to BUSY.
    - If access and misaligned: m_stall=0; no request; m_mem_exc=1 with code 01 next cycle; m_mem_data=0.
    - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
    - No access: m_stall=0.
    - dmem_ack in IDLE is ignored.
  - BUSY: m_stall=1; request signals held stable; counter increments each cycle.
    - On dmem_ack: drop dmem_req. For loads, capture formatted dmem_rdata into m_mem_data; for stores, m_mem_data is unchanged. Go to DONE.
    - If the counter reaches TIMEOUT_CYCLES without ack: drop dmem_req, m_mem_data=0, m_mem_exc pulse with code 10, go to DONE.
    - If ack and timeout occur in the same cycle, ack wins.
  - DONE: m_stall=0, so the pipeline advances at this edge; clear counter; go to IDLE. The next instruction is evaluated in IDLE the following cycle, so the same access is never reissued.
- Latency:
  - Zero-wait memory (ack in the first BUSY cycle): 3 cycles from the instruction's arrival to the pipeline advancing, i.e. 2 stall cycles.
  - Each extra wait cycle adds 1.
- Byte lanes (little-endian, lane = addr[1:0]):
  - Byte: be=0001<<lane; wdata is the byte replicated 4×.
  - Half: be=0011<<(2*addr[1]); wdata is the half replicated 2×.
  - Word: be=1111.
- Load format: extract the addressed lane and extend to 32 bits per m_mem_signed.
- Reset mid-operation: the outstanding request is abandoned and dmem_req drops immediately. A late ack is then seen in IDLE and ignored.

Decomposition:
- Shared package mem_pkg:
  - size encodings MEM_BYTE/MEM_HALF/MEM_WORD;
  - exception codes EXC_NONE/EXC_MISALIGN/EXC_TIMEOUT;
  - state encoding S_IDLE/S_BUSY/S_DONE.
- One combinational sub-module, mem_lane_align: computes be/wdata from size/addr/store data and load extraction/extension from rdata.
- The FSM and counter stay in the top module.

Test Plan:
- Word load, addr 0x0000_0010, ack in the first BUSY cycle, rdata 0xDEAD_BEEF -> dmem_addr 0x10, be 1111, m_stall high for exactly 2 cycles, m_mem_data 0xDEAD_BEEF in DONE.
- Signed byte load, addr 0x13, rdata 0x8000_0000 -> m_mem_data 0xFFFF_FF80. Same access unsigned -> 0x0000_0080.
- Half store, addr 0x22, store data 0x0000_1234, ack after 4 wait cycles -> be 1100, wdata 0x1234_1234, dmem_we 1, m_stall high for 6 cycles.
- Word load, addr 0x06 -> no dmem_req, m_stall 0, m_mem_exc pulse with code 01.
- TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 BUSY cycles, exc code 10, m_mem_data 0, return to IDLE.
- reset low in the second BUSY cycle -> dmem_req 0 asynchronously. A subsequent ack with reset high is ignored: no stall, no data capture.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access stage.
// Provides access-size, exception-code and FSM-state encodings, the ack-timeout
// counter width, and the alignment rule shared by the stage and its checks.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11   // behaves as a word access
    } mem_size_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_TIMEOUT  = 2'b10
    } exc_code_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Wide enough for the largest legal timeout (255).
    localparam int unsigned TO_CNT_W = 8;

    // Half needs an even address, word (and reserved) a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = lane[0];
            default:  mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory port bundle with a req/ack handshake.
//   dmem_req   request valid, held until dmem_ack
//   dmem_we    write enable
//   dmem_addr  word-aligned byte address
//   dmem_wdata lane-replicated write data
//   dmem_be    byte enables
//   dmem_ack   single-cycle completion strobe
//   dmem_rdata read word, valid with dmem_ack
// master: the pipeline stage; slave: the memory.
interface memory_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory stage.
// Store side: byte enables and lane-replicated write data from size/lane/data.
// Load side: extracts the addressed lane of the read word and sign- or
// zero-extends it to 32 bits.
//   st_size_i/st_lane_i/st_data_i  store request (lane = addr[1:0])
//   be_o/wdata_o                   byte enables and replicated write data
//   ld_size_i/ld_lane_i/ld_signed_i/rdata_i  captured load request and read word
//   ld_data_o                      formatted load result
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_lane_i,
    input  logic        ld_signed_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
        case (st_size_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << st_lane_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            MEM_HALF: begin
                be_o    = st_lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        // Bring the addressed lane down to bit 0 before extension.
        ld_shift  = rdata_i >> {ld_lane_i, 3'b000};
        ld_data_o = rdata_i;
        case (ld_size_i)
            MEM_BYTE: ld_data_o = {{24{ld_signed_i & ld_shift[7]}}, ld_shift[7:0]};
            MEM_HALF: ld_data_o = {{16{ld_signed_i & ld_shift[15]}}, ld_shift[15:0]};
            default:  ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage of the 5-stage pipeline. Issues loads/stores on the data-memory
// port, stalls the pipeline while an access is outstanding, formats load data
// for the writeback latch, and flags misaligned accesses and ack timeouts.
//   clock, reset            pipeline clock, async active-low reset
//   m_mem_read/m_mem_write  load / store request from the EX/MEM latch
//   m_mem_size/m_mem_signed access size and load extension
//   m_alu_result            byte address; m_store_data right-aligned store data
//   m_mem_data              formatted load data to MEM/WB
//   m_stall                 combinational pipeline freeze
//   m_mem_exc/_code         one-cycle exception pulse and its cause
//   dmem                    data-memory port (master side)
module memory_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic [1:0]  m_mem_size,
    input  logic        m_mem_signed,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_store_data,
    output logic [31:0] m_mem_data,
    output logic        m_stall,
    output logic        m_mem_exc,
    output logic [1:0]  m_mem_exc_code,
    memory_access_stage_if.master dmem
);

    // Counter value seen in the last BUSY cycle allowed before aborting.
    localparam logic [TO_CNT_W-1:0] ToLast = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         data_q, data_d;
    logic                exc_q, exc_d;
    exc_code_e           code_q, code_d;
    // Load formatting info captured at issue so BUSY does not rely on upstream.
    logic [1:0]          ld_size_q, ld_size_d;
    logic [1:0]          ld_lane_q, ld_lane_d;
    logic                ld_signed_q, ld_signed_d;

    logic                access;
    logic                misaligned;
    logic [3:0]          st_be;
    logic [31:0]         st_wdata;
    logic [31:0]         ld_data;

    assign access     = m_mem_read | m_mem_write;
    assign misaligned = is_misaligned(m_mem_size, m_alu_result[1:0]);

    mem_lane_align u_lane_align (
        .st_size_i   (m_mem_size),
        .st_lane_i   (m_alu_result[1:0]),
        .st_data_i   (m_store_data),
        .be_o        (st_be),
        .wdata_o     (st_wdata),
        .ld_size_i   (ld_size_q),
        .ld_lane_i   (ld_lane_q),
        .ld_signed_i (ld_signed_q),
        .rdata_i     (dmem.dmem_rdata),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        data_d      = data_q;
        exc_d       = 1'b0;
        code_d      = EXC_NONE;
        ld_size_d   = ld_size_q;
        ld_lane_d   = ld_lane_q;
        ld_signed_d = ld_signed_q;
        m_stall     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // dmem_ack is deliberately ignored here (late ack after reset).
                if (access) begin
                    if (!misaligned) begin
                        m_stall     = 1'b1;
                        req_d       = 1'b1;
                        we_d        = m_mem_write;
                        addr_d      = {m_alu_result[31:2], 2'b00};
                        be_d        = st_be;
                        wdata_d     = st_wdata;
                        ld_size_d   = m_mem_size;
                        ld_lane_d   = m_alu_result[1:0];
                        ld_signed_d = m_mem_signed;
                        cnt_d       = '0;
                        state_d     = S_BUSY;
                    end else begin
                        // Instruction retires without touching memory.
                        exc_d  = 1'b1;
                        code_d = EXC_MISALIGN;
                        data_d = '0;
                    end
                end
            end
            S_BUSY: begin
                m_stall = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // Ack has priority over a coincident timeout.
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        data_d = ld_data;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == ToLast) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    data_d  = '0;
                    exc_d   = 1'b1;
                    code_d  = EXC_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Stall released: the pipeline advances on this edge.
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            data_q      <= '0;
            exc_q       <= 1'b0;
            code_q      <= EXC_NONE;
            ld_size_q   <= MEM_BYTE;
            ld_lane_q   <= '0;
            ld_signed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            data_q      <= data_d;
            exc_q       <= exc_d;
            code_q      <= code_d;
            ld_size_q   <= ld_size_d;
            ld_lane_q   <= ld_lane_d;
            ld_signed_q <= ld_signed_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign m_mem_data      = data_q;
    assign m_mem_exc       = exc_q;
    assign m_mem_exc_code  = code_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: reset values, a table of directed accesses
// (including a TIMEOUT_CYCLES=4 instance for the timeout boundary), a mid-access
// reset sequence, and random accesses against a behavioural model.
module tb_memory_access_stage;
    import mem_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, sgn = 1'b0, sel = 1'b0, ack = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, sdata = '0, rdata = '0;

    logic [31:0] data_m, data_t;
    logic        stall_m, stall_t, exc_m, exc_t;
    logic [1:0]  code_m, code_t;

    memory_access_stage_if bus ();
    memory_access_stage_if bus_to ();
    assign bus.dmem_ack      = ack & ~sel;
    assign bus.dmem_rdata    = rdata;
    assign bus_to.dmem_ack   = ack & sel;
    assign bus_to.dmem_rdata = rdata;

    memory_access_stage dut (
        .clock          (clock),
        .reset          (reset),
        .m_mem_read     (rd & ~sel),
        .m_mem_write    (wr & ~sel),
        .m_mem_size     (size),
        .m_mem_signed   (sgn),
        .m_alu_result   (addr),
        .m_store_data   (sdata),
        .m_mem_data     (data_m),
        .m_stall        (stall_m),
        .m_mem_exc      (exc_m),
        .m_mem_exc_code (code_m),
        .dmem           (bus)
    );

    memory_access_stage #(.TIMEOUT_CYCLES(4)) dut_to (
        .clock          (clock),
        .reset          (reset),
        .m_mem_read     (rd & sel),
        .m_mem_write    (wr & sel),
        .m_mem_size     (size),
        .m_mem_signed   (sgn),
        .m_alu_result   (addr),
        .m_store_data   (sdata),
        .m_mem_data     (data_t),
        .m_stall        (stall_t),
        .m_mem_exc      (exc_t),
        .m_mem_exc_code (code_t),
        .dmem           (bus_to)
    );

    // Observed view of whichever DUT is selected.
    logic        s_stall, s_exc, s_req, s_we;
    logic [1:0]  s_code;
    logic [3:0]  s_be;
    logic [31:0] s_data, s_addr, s_wdata;
    always_comb begin
        if (sel) begin
            s_stall = stall_t; s_exc = exc_t; s_code = code_t; s_data = data_t;
            s_req = bus_to.dmem_req; s_we = bus_to.dmem_we; s_be = bus_to.dmem_be;
            s_addr = bus_to.dmem_addr; s_wdata = bus_to.dmem_wdata;
        end else begin
            s_stall = stall_m; s_exc = exc_m; s_code = code_m; s_data = data_m;
            s_req = bus.dmem_req; s_we = bus.dmem_we; s_be = bus.dmem_be;
            s_addr = bus.dmem_addr; s_wdata = bus.dmem_wdata;
        end
    end

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr, sdata, rdata;
        int          ack_wait;   // BUSY cycles before ack; -1 = never
        logic        sel;        // 1 = TIMEOUT_CYCLES=4 instance
    } op_t;

    typedef struct {
        int          stalls, req_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] data;
        int          exc_cnt;
        logic [1:0]  code;
        logic        unstable;
    } res_t;

    typedef struct { op_t op; res_t exp; } vec_t;

    int n_chk = 0, n_pass = 0;
    logic [31:0] model_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic op_t mk_op(input logic r, input logic w, input logic [1:0] sz,
                                  input logic sg, input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rdt, input int aw, input logic s);
        op_t o;
        o.rd = r; o.wr = w; o.size = sz; o.sgn = sg; o.addr = a; o.sdata = sd;
        o.rdata = rdt; o.ack_wait = aw; o.sel = s;
        return o;
    endfunction

    function automatic res_t mk_res(input int st, input int rc, input logic [31:0] a,
                                    input logic [3:0] b, input logic [31:0] wd, input logic w,
                                    input logic [31:0] d, input int ec, input logic [1:0] c);
        res_t r;
        r.stalls = st; r.req_cycles = rc; r.addr = a; r.be = b; r.wdata = wd; r.we = w;
        r.data = d; r.exc_cnt = ec; r.code = c; r.unstable = 1'b0;
        return r;
    endfunction

    // Reference model: outcome of one instruction from the access rules.
    function automatic res_t model(input op_t op, input logic [31:0] prev);
        res_t e;
        int lane, eff;
        logic [31:0] v;
        e = mk_res(0, 0, 0, 0, 0, 0, prev, 0, 2'b00);
        lane = int'(op.addr % 4);
        eff  = (op.size == 2'd3) ? 2 : int'(op.size);
        if (!(op.rd || op.wr)) return e;
        if ((eff == 1 && (lane % 2) != 0) || (eff == 2 && lane != 0)) begin
            e.data = 0; e.exc_cnt = 1; e.code = 2'b01;
            return e;
        end
        e.stalls     = op.ack_wait + 2;
        e.req_cycles = op.ack_wait + 1;
        e.addr       = op.addr - 32'(lane);
        e.we         = op.wr;
        v = op.rdata >> (8 * lane);
        if (eff == 0) begin
            e.be    = 4'(1 << lane);
            e.wdata = (op.sdata % 256) * 32'h0101_0101;
            v = v % 256;
            if (op.sgn && v >= 128) v = v - 32'd256;
        end else if (eff == 1) begin
            e.be    = 4'(3 << lane);
            e.wdata = (op.sdata % 65536) * 32'h0001_0001;
            v = v % 65536;
            if (op.sgn && v >= 32768) v = v - 32'd65536;
        end else begin
            e.be    = 4'hF;
            e.wdata = op.sdata;
            v = op.rdata;
        end
        e.data = op.wr ? prev : v;
        return e;
    endfunction

    task automatic run_op(input op_t op, output res_t r);
        int   cyc;
        logic fin;
        r = mk_res(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        @(negedge clock);
        sel = op.sel; rd = op.rd; wr = op.wr; size = op.size; sgn = op.sgn;
        addr = op.addr; sdata = op.sdata; rdata = op.rdata;
        #1;
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 400) begin
            if (s_exc) begin r.exc_cnt++; r.code = s_code; end
            if (s_stall) r.stalls++;
            if (s_req) begin
                if (r.req_cycles == 0) begin
                    r.addr = s_addr; r.be = s_be; r.wdata = s_wdata; r.we = s_we;
                end else if (r.addr !== s_addr || r.be !== s_be || r.wdata !== s_wdata
                             || r.we !== s_we) begin
                    r.unstable = 1'b1;
                end
                r.req_cycles++;
                if (op.ack_wait >= 0 && r.req_cycles == op.ack_wait + 1) ack = 1'b1;
            end
            if (!s_stall) fin = 1'b1;
            @(posedge clock);
            #1;
            ack = 1'b0;
            cyc++;
        end
        if (!fin) r.stalls = -1;
        rd = 1'b0;
        wr = 1'b0;
        r.data = s_data;
        if (s_exc) begin r.exc_cnt++; r.code = s_code; end
        @(posedge clock);
        #1;
        if (s_exc) begin r.exc_cnt++; r.code = s_code; end
    endtask

    task automatic cmp_res(input string nm, input res_t r, input res_t e);
        chk({nm, ".stalls"}, 32'(r.stalls), 32'(e.stalls));
        chk({nm, ".req_cycles"}, 32'(r.req_cycles), 32'(e.req_cycles));
        chk({nm, ".addr"}, r.addr, e.addr);
        chk({nm, ".be"}, 32'(r.be), 32'(e.be));
        chk({nm, ".wdata"}, r.wdata, e.wdata);
        chk({nm, ".we"}, 32'(r.we), 32'(e.we));
        chk({nm, ".data"}, r.data, e.data);
        chk({nm, ".exc_cnt"}, 32'(r.exc_cnt), 32'(e.exc_cnt));
        chk({nm, ".code"}, 32'(r.code), 32'(e.code));
        chk({nm, ".stable"}, 32'(r.unstable), 32'(e.unstable));
    endtask

    vec_t vecs[$];

    initial begin
        res_t r, e;
        op_t  o;
        vec_t v;

        // Directed table: op, then expected outcome.
        v.op = mk_op(1, 0, 2'd2, 0, 32'h10, 0, 32'hDEAD_BEEF, 0, 0);
        v.exp = mk_res(2, 1, 32'h10, 4'hF, 0, 0, 32'hDEAD_BEEF, 0, 2'b00); vecs.push_back(v);
        v.op = mk_op(1, 0, 2'd0, 1, 32'h13, 0, 32'h8000_0000, 0, 0);
        v.exp = mk_res(2, 1, 32'h10, 4'h8, 0, 0, 32'hFFFF_FF80, 0, 2'b00); vecs.push_back(v);
        v.op = mk_op(1, 0, 2'd0, 0, 32'h13, 0, 32'h8000_0000, 0, 0);
        v.exp = mk_res(2, 1, 32'h10, 4'h8, 0, 0, 32'h0000_0080, 0, 2'b00); vecs.push_back(v);
        v.op = mk_op(0, 1, 2'd1, 0, 32'h22, 32'h0000_1234, 0, 4, 0);
        v.exp = mk_res(6, 5, 32'h20, 4'hC, 32'h1234_1234, 1, 32'h0000_0080, 0, 2'b00);
        vecs.push_back(v);
        v.op = mk_op(1, 0, 2'd2, 0, 32'h06, 0, 32'h5555_5555, 0, 0);
        v.exp = mk_res(0, 0, 0, 0, 0, 0, 0, 1, 2'b01); vecs.push_back(v);
        v.op = mk_op(1, 0, 2'd1, 1, 32'h22, 0, 32'hABCD_1234, 2, 0);
        v.exp = mk_res(4, 3, 32'h20, 4'hC, 0, 0, 32'hFFFF_ABCD, 0, 2'b00); vecs.push_back(v);
        v.op = mk_op(0, 1, 2'd0, 0, 32'h41, 32'hFFFF_FF5A, 0, 1, 0);
        v.exp = mk_res(3, 2, 32'h40, 4'h2, 32'h5A5A_5A5A, 1, 32'hFFFF_ABCD, 0, 2'b00);
        vecs.push_back(v);
        v.op = mk_op(1, 0, 2'd1, 0, 32'h31, 0, 0, 0, 0);
        v.exp = mk_res(0, 0, 0, 0, 0, 0, 0, 1, 2'b01); vecs.push_back(v);
        v.op = mk_op(1, 0, 2'd3, 0, 32'h08, 0, 32'h1234_5678, 0, 0);
        v.exp = mk_res(2, 1, 32'h08, 4'hF, 0, 0, 32'h1234_5678, 0, 2'b00); vecs.push_back(v);
        v.op = mk_op(0, 0, 2'd2, 0, 32'h08, 0, 0, 0, 0);
        v.exp = mk_res(0, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 2'b00); vecs.push_back(v);
        v.op = mk_op(1, 0, 2'd1, 0, 32'h02, 0, 32'h8001_FFFF, 0, 0);
        v.exp = mk_res(2, 1, 32'h00, 4'hC, 0, 0, 32'h0000_8001, 0, 2'b00); vecs.push_back(v);
        // TIMEOUT_CYCLES=4: ack in the last allowed cycle wins, then a true timeout.
        v.op = mk_op(1, 0, 2'd2, 0, 32'h08, 0, 32'h0BAD_F00D, 3, 1);
        v.exp = mk_res(5, 4, 32'h08, 4'hF, 0, 0, 32'h0BAD_F00D, 0, 2'b00); vecs.push_back(v);
        v.op = mk_op(1, 0, 2'd2, 0, 32'h0C, 0, 32'h7777_7777, -1, 1);
        v.exp = mk_res(5, 4, 32'h0C, 4'hF, 0, 0, 0, 1, 2'b10); vecs.push_back(v);

        // Reset state.
        #1;
        chk("rst.req", 32'(bus.dmem_req), 0);
        chk("rst.we", 32'(bus.dmem_we), 0);
        chk("rst.addr", bus.dmem_addr, 0);
        chk("rst.wdata", bus.dmem_wdata, 0);
        chk("rst.be", 32'(bus.dmem_be), 0);
        chk("rst.data", data_m, 0);
        chk("rst.exc", 32'(exc_m), 0);
        chk("rst.code", 32'(code_m), 0);
        chk("rst.stall", 32'(stall_m), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, r);
            cmp_res($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // Reset during the second BUSY cycle, then a late ack in IDLE.
        @(negedge clock);
        sel = 1'b0; rd = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h40; rdata = 32'h1234_5678;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("midrst.req_before", 32'(bus.dmem_req), 1);
        reset = 1'b0;
        rd = 1'b0;
        #1;
        chk("midrst.req_async", 32'(bus.dmem_req), 0);
        chk("midrst.stall", 32'(stall_m), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        ack = 1'b1;
        #1;
        chk("lateack.stall", 32'(stall_m), 0);
        @(posedge clock);
        #1;
        ack = 1'b0;
        chk("lateack.data", data_m, 0);
        chk("lateack.req", 32'(bus.dmem_req), 0);
        chk("lateack.exc", 32'(exc_m), 0);

        // Random accesses against the model.
        model_data = 32'h0;
        for (int n = 0; n < 40; n++) begin
            int k;
            k = int'($urandom_range(0, 9));
            o = mk_op(k >= 1 && k <= 5, k >= 6, 2'($urandom_range(0, 3)), 1'($urandom),
                      $urandom, $urandom, $urandom, int'($urandom_range(0, 6)), 0);
            if ($urandom_range(0, 3) != 0) begin
                if (o.size == 2'd1) o.addr[0] = 1'b0;
                else if (o.size != 2'd0) o.addr[1:0] = 2'b00;
            end
            e = model(o, model_data);
            run_op(o, r);
            cmp_res($sformatf("rnd%0d", n), r, e);
            model_data = e.data;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
